// File: rtl/adc_window_integrator_pkg.sv
// Shared definitions for the ADC window integrator: default widths and FSM state encoding.
package adc_window_integrator_pkg;

    localparam int DW_DEF   = 14;
    localparam int DLYW_DEF = 8;
    localparam int LENW_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_INTEG = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/adc_window_integrator.sv
// Per-trigger windowed integrator: waits a programmable delay, then sums and
// peak-tracks `length` signed samples and strobes one result per trigger.
module adc_window_integrator
    import adc_window_integrator_pkg::*;
#(
    parameter int  DW   = DW_DEF,
    parameter int  DLYW = DLYW_DEF,
    parameter int  LENW = LENW_DEF,
    localparam int ACCW = DW + LENW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trig,
    input  logic signed [DW-1:0]   din,
    input  logic [DLYW-1:0]        delay,
    input  logic [LENW-1:0]        length,
    input  logic                   clr_missed,
    output logic signed [ACCW-1:0] sum,
    output logic signed [DW-1:0]   peak,
    output logic                   sum_valid,
    output logic                   busy,
    output logic                   missed_trig
);

    localparam int CW = (DLYW > LENW) ? DLYW : LENW;

    state_e                 state_q;
    logic [DLYW-1:0]        dly_q;
    logic [LENW-1:0]        len_q;
    logic [CW-1:0]          cnt_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [DW-1:0]   pk_q;

    logic signed [ACCW-1:0] samp_ext_s;
    logic                   first_s;
    logic                   dly_last_s;
    logic                   integ_last_s;

    // Sample sign extension and window-position decodes.
    always_comb begin
        samp_ext_s   = {{LENW{din[DW-1]}}, din};
        first_s      = (cnt_q == '0);
        dly_last_s   = (cnt_q == (CW'(dly_q) - CW'(1'b1)));
        integ_last_s = (cnt_q == (CW'(len_q) - CW'(1'b1)));
    end

    // Control FSM with counters, accumulator/peak datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dly_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            pk_q        <= '0;
            sum         <= '0;
            peak        <= '0;
            sum_valid   <= 1'b0;
            busy        <= 1'b0;
            missed_trig <= 1'b0;
        end else begin
            sum_valid <= 1'b0;

            // A dropped trigger wins over a simultaneous clear.
            if (trig && (state_q != ST_IDLE)) begin
                missed_trig <= 1'b1;
            end else if (clr_missed) begin
                missed_trig <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (trig && (length != '0)) begin
                        dly_q   <= delay;
                        len_q   <= length;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= (delay == '0) ? ST_INTEG : ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dly_last_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_INTEG;
                    end else begin
                        cnt_q <= cnt_q + CW'(1'b1);
                    end
                end
                ST_INTEG: begin
                    acc_q <= first_s ? samp_ext_s : (acc_q + samp_ext_s);
                    pk_q  <= (first_s || (din > pk_q)) ? din : pk_q;
                    if (integ_last_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1'b1);
                    end
                end
                ST_DONE: begin
                    sum       <= acc_q;
                    peak      <= pk_q;
                    sum_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_window_integrator.sv
// Directed bench for adc_window_integrator with a cycle-indexed window model
// compared every cycle, plus hand-computed checks on each scenario.
module tb_adc_window_integrator;

    localparam int HN = 1024;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               trig = 1'b0;
    logic               clr_missed = 1'b0;
    logic signed [13:0] din = 14'sd0;
    logic [7:0]         delay = 8'd0;
    logic [5:0]         length = 6'd0;
    logic signed [19:0] sum;
    logic signed [13:0] peak;
    logic               sum_valid;
    logic               busy;
    logic               missed_trig;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;
    int mode    = 0;
    int cval    = 0;

    adc_window_integrator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .din        (din),
        .delay      (delay),
        .length     (length),
        .clr_missed (clr_missed),
        .sum        (sum),
        .peak       (peak),
        .sum_valid  (sum_valid),
        .busy       (busy),
        .missed_trig(missed_trig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted trigger defines a window of absolute edge indices.
    logic signed [13:0] hist [HN];
    int     cyc = 0;
    bit     win_act = 1'b0;
    int     w_start = 0, w_len = 0, w_end = 0;
    longint m_sum = 0, m_peak = 0;
    bit     m_valid = 1'b0, m_busy = 1'b0, m_missed = 1'b0;

    function automatic longint win_sum(input int s, input int n);
        longint a = 0;
        for (int i = 0; i < n; i++) a += longint'(hist[(s + i) % HN]);
        return a;
    endfunction

    function automatic longint win_peak(input int s, input int n);
        longint p = longint'(hist[s % HN]);
        for (int i = 1; i < n; i++)
            if (longint'(hist[(s + i) % HN]) > p) p = longint'(hist[(s + i) % HN]);
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_act  <= 1'b0;
            m_sum    <= 0;
            m_peak   <= 0;
            m_valid  <= 1'b0;
            m_busy   <= 1'b0;
            m_missed <= 1'b0;
        end else begin
            cyc            <= cyc + 1;
            hist[cyc % HN] <= din;
            m_valid        <= 1'b0;
            if (win_act && (cyc == w_end)) begin
                m_sum   <= win_sum(w_start, w_len);
                m_peak  <= win_peak(w_start, w_len);
                m_valid <= 1'b1;
                m_busy  <= 1'b0;
                win_act <= 1'b0;
            end
            if (trig && win_act) m_missed <= 1'b1;
            else if (clr_missed) m_missed <= 1'b0;
            if (trig && !win_act && (length != 6'd0)) begin
                win_act <= 1'b1;
                m_busy  <= 1'b1;
                w_start <= cyc + 1 + int'(delay);
                w_len   <= int'(length);
                w_end   <= cyc + int'(delay) + int'(length) + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_sum", longint'(sum), m_sum);
            chk("m_peak", longint'(peak), m_peak);
            chk("m_valid", longint'(sum_valid), longint'(m_valid));
            chk("m_busy", longint'(busy), longint'(m_busy));
            chk("m_missed", longint'(missed_trig), longint'(m_missed));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_trig(input int d, input int l);
        delay  = 8'(d);
        length = 6'(l);
        trig   = 1'b1;
        tick();
        trig   = 1'b0;
    endtask

    // Drives din for edge T+k (ramp gives 1 at the first window sample) until the strobe.
    task automatic wait_valid(input int d, input int k0, output int lat);
        lat = -1;
        for (int k = k0; k <= k0 + 400; k++) begin
            if (mode == 0) din = 14'(k - d);
            else           din = 14'(cval);
            tick();
            if (sum_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_total++;
            n_bad++;
            $display("FAIL valid_timeout: got no strobe expected one within 400 cycles");
        end
    endtask

    initial begin
        int lat;
        int nv;

        repeat (2) tick();
        chk_en = 1'b1;
        chk("rst_sum", longint'(sum), 0);
        chk("rst_peak", longint'(peak), 0);
        chk("rst_valid", longint'(sum_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_missed", longint'(missed_trig), 0);
        rst_n = 1'b1;
        tick();

        // Ramp, no delay.
        mode = 0;
        issue_trig(0, 4);
        chk("t1_busy_hi", longint'(busy), 1);
        wait_valid(0, 1, lat);
        chk("t1_lat", lat, 5);
        chk("t1_sum", longint'(sum), 10);
        chk("t1_peak", longint'(peak), 4);
        chk("t1_busy_lo", longint'(busy), 0);
        tick();

        // Constant negative with delay.
        mode = 1; cval = -100;
        issue_trig(3, 2);
        wait_valid(3, 1, lat);
        chk("t2_lat", lat, 6);
        chk("t2_sum", longint'(sum), -200);
        chk("t2_peak", longint'(peak), -100);
        chk("t2_busy_lo", longint'(busy), 0);
        tick();
        chk("t2_hold", longint'(sum), -200);

        // Full-scale extremes.
        cval = -8192;
        issue_trig(0, 63);
        wait_valid(0, 1, lat);
        chk("t3_lat", lat, 64);
        chk("t3_sum", longint'(sum), -516096);
        chk("t3_peak", longint'(peak), -8192);
        cval = 8191;
        issue_trig(255, 63);
        wait_valid(255, 1, lat);
        chk("t4_lat", lat, 319);
        chk("t4_sum", longint'(sum), 516033);
        chk("t4_peak", longint'(peak), 8191);
        tick();

        // Dropped trigger during the delay.
        mode = 0; din = 14'sd0;
        issue_trig(5, 8);
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t5_missed_set", longint'(missed_trig), 1);
        wait_valid(5, 3, lat);
        chk("t5_lat", lat, 14);
        chk("t5_sum", longint'(sum), 36);
        chk("t5_peak", longint'(peak), 8);
        clr_missed = 1'b1;
        tick();
        clr_missed = 1'b0;
        chk("t5_missed_clr", longint'(missed_trig), 0);
        issue_trig(5, 8);
        trig = 1'b1; clr_missed = 1'b1;
        tick();
        trig = 1'b0; clr_missed = 1'b0;
        chk("t5_set_wins", longint'(missed_trig), 1);
        wait_valid(5, 2, lat);
        chk("t5b_sum", longint'(sum), 36);
        clr_missed = 1'b1;
        tick();
        clr_missed = 1'b0;

        // Zero length is ignored.
        issue_trig(3, 0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sum_valid || busy) nv++;
        end
        chk("t6_len0_idle", nv, 0);
        chk("t6_len0_missed", longint'(missed_trig), 0);

        // Settings changed mid-window have no effect.
        issue_trig(2, 3);
        delay = 8'd0; length = 6'd10;
        wait_valid(2, 1, lat);
        chk("t7_lat", lat, 6);
        chk("t7_sum", longint'(sum), 6);
        chk("t7_peak", longint'(peak), 3);
        tick();

        // Asynchronous reset mid-integration.
        mode = 1; cval = 5;
        issue_trig(0, 10);
        din = 14'sd5;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_sum", longint'(sum), 0);
        chk("t8_rst_peak", longint'(peak), 0);
        chk("t8_rst_busy", longint'(busy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (sum_valid) nv++;
        end
        chk("t8_no_strobe", nv, 0);
        cval = 7;
        issue_trig(1, 5);
        wait_valid(1, 1, lat);
        chk("t8_lat", lat, 7);
        chk("t8_sum", longint'(sum), 35);
        chk("t8_peak", longint'(peak), 7);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
